// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain that pops one word per frame and sends it as 8N1 UART
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  ren_q, ren_d;
  logic                  cnt_wrap;

  assign cnt_wrap      = (cnt_q == CNT_MAX);
  assign fifo_r_enable = ren_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign tx_done       = (state_q == S_STOP) && cnt_wrap;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ren_q   <= ren_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ren_d   = 1'b0;
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          ren_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      // The FIFO presents the popped word on the edge leaving FETCH.
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo_r_data;
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_wrap) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_wrap) begin
          if (idx_q == IDX_MAX) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (cnt_wrap) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx with a small FIFO model
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int CPB = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW:0]   fifo_count;
  logic [DW-1:0] fifo_r_data = '0;
  logic          fifo_r_enable;
  logic          tx;
  logic          busy;
  logic          tx_done;

  logic [DW-1:0] mem [0:15];
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr = '0;
  logic          ovr_en = 1'b0;
  logic [AW:0]   ovr_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign fifo_count = ovr_en ? ovr_val : (wr_ptr - rd_ptr);

  always @(posedge CLK) begin
    if (fifo_r_enable) begin
      fifo_r_data <= mem[rd_ptr[3:0]];
      rd_ptr      <= rd_ptr + 1'b1;
    end
  end

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .fifo_count   (fifo_count),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_enable(fifo_r_enable),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic wait_ren(output int waited);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (fifo_r_enable !== 1'b1 && waited < 2000);
    check("ren_seen", fifo_r_enable, 1);
  endtask

  // Returns sampled at negedge n=40 (first IDLE cycle after the stop bit).
  task automatic run_frame(input logic [DW-1:0] b, input int zero_at, output int waited);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    wait_ren(waited);
    check("busy_fetch", busy, 1);
    @(negedge CLK);
    check("ren_width", fifo_r_enable, 0);
    check("tx_before_start", tx, 1);
    @(negedge CLK);
    for (int n = 0; n < 40; n++) begin
      if (n == zero_at) begin
        ovr_val = '0;
        ovr_en  = 1'b1;
      end
      check($sformatf("tx_n%0d", n), tx, f[n / CPB]);
      check($sformatf("done_n%0d", n), tx_done, (n == 39) ? 1 : 0);
      check("busy_frame", busy, 1);
      check("ren_frame", fifo_r_enable, 0);
      @(negedge CLK);
    end
    check("tx_idle_after", tx, 1);
    check("busy_after", busy, 0);
    check("done_after", tx_done, 0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int ren_hits, tx_low, busy_hits;
    ren_hits = 0;
    tx_low = 0;
    busy_hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (fifo_r_enable !== 1'b0) ren_hits++;
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_hits++;
    end
    check({tag, "_ren"}, ren_hits, 0);
    check({tag, "_tx"}, tx_low, 0);
    check({tag, "_busy"}, busy_hits, 0);
  endtask

  initial begin
    int w;
    ovr_en  = 1'b1;
    ovr_val = 9'd5;
    RST_N   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ren", fifo_r_enable, 0);
      check("rst_done", tx_done, 0);
    end
    ovr_en = 1'b0;
    RST_N  = 1'b1;

    push(8'hA5);
    run_frame(8'hA5, -1, w);
    quiet(20, "after_a5");

    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    run_frame(8'h00, -1, w);
    run_frame(8'hFF, -1, w);
    check("gap_ff", w, 1);
    run_frame(8'h3C, -1, w);
    check("gap_3c", w, 1);
    check("count_drained", fifo_count, 0);
    quiet(100, "no_fourth_pop");

    quiet(1000, "empty");

    push(8'h5A);
    wait_ren(w);
    @(negedge CLK);
    @(negedge CLK);
    for (int n = 0; n < 17; n++) @(negedge CLK);
    check("bit3_5a", tx, 1);
    check("busy_bit3", busy, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", tx_done, 0);
    RST_N = 1'b1;
    check("midrst_count", fifo_count, 0);
    quiet(200, "after_midrst");

    push(8'h96);
    push(8'h11);
    run_frame(8'h96, 10, w);
    quiet(200, "count_zeroed");
    ovr_en = 1'b0;
    run_frame(8'h11, -1, w);
    quiet(20, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain side of the echo path. Watches the FIFO occupancy count, pops one word whenever the FIFO is non-empty and the line is idle, and serialises it as 8N1 UART on `tx`. It sits between the FIFO read port (`r_enable`, `r_data`, `count`) and the board's UART TX pin, and is the only agent allowed to drive the FIFO read side.

## Interface

Parameters:
- `DATA_WIDTH`, 8: data bits per frame; must match the FIFO data width.
- `ADDR_WIDTH`, 8: FIFO address width; `fifo_count` is `ADDR_WIDTH+1` bits.
- `CLKS_PER_BIT`, 868: `CLK` cycles per UART bit (100 MHz / 115200). Must be ≥ 2.

Ports:
- `CLK`, input, 1: single clock; all logic on the rising edge.
- `RST_N`, input, 1: reset, synchronous, active-low.
- `fifo_count`, input, `ADDR_WIDTH+1`: FIFO occupancy.
- `fifo_r_data`, input, `DATA_WIDTH`: FIFO read data, registered by the FIFO on the edge where `r_enable` is sampled high.
- `fifo_r_enable`, output, 1: FIFO pop strobe, registered, exactly one cycle high per frame.
- `tx`, output, 1: serial line, idle high, registered.
- `busy`, output, 1: high from the FETCH state through the end of STOP.
- `tx_done`, output, 1: one-cycle pulse on the last cycle of the stop bit.

## Operation

- Reset (`RST_N`=0 at an edge): state IDLE, `tx`=1, `busy`=0, `fifo_r_enable`=0, `tx_done`=0, baud counter and bit index cleared, shift register cleared. This applies mid-frame too: the line returns high on that edge and the popped byte is discarded.
- States:
  - **IDLE**: if `fifo_count` != 0, set `fifo_r_enable`<=1 and `busy`<=1, then go to FETCH.
  - **FETCH**: set `fifo_r_enable`<=0 and go to LOAD. On this edge the FIFO updates `r_data`.
  - **LOAD**: set shift register <= `fifo_r_data` and `tx`<=0, clear the baud counter, go to START.
  - **START**: hold `tx`=0 for `CLKS_PER_BIT` cycles. On counter wrap, drive `tx`<=shift[0], set bit index 0, go to DATA.
  - **DATA**: each bit is held `CLKS_PER_BIT` cycles, LSB first. On wrap, shift right and drive the next bit. After bit `DATA_WIDTH-1` wraps, drive `tx`<=1 and go to STOP.
  - **STOP**: hold `tx`=1 for `CLKS_PER_BIT` cycles. On the final cycle, `tx_done`=1. On wrap, set `busy`<=0 and go to IDLE.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT-1` and wraps to 0.
- Bit index width is `$clog2(DATA_WIDTH)`. Wrap-around is never used; the terminal test is index == `DATA_WIDTH-1`.
- Pop once per frame only. `fifo_count` lags `r_enable` by one cycle, but the next IDLE check happens ≥ `(DATA_WIDTH+2)*CLKS_PER_BIT` cycles later, so a double pop is impossible.
- Empty FIFO: the block stays in IDLE with `tx`=1 and never asserts `fifo_r_enable`.
- Full FIFO: no special handling; the block simply drains.
- `fifo_count` changing during a frame is ignored.

## Timing

- Let edge k be the edge where IDLE sees `fifo_count` != 0.
  - `fifo_r_enable` is high for the cycle after edge k.
  - The start bit begins at edge k+2, i.e. `tx` falls 2 cycles after `r_enable` rises.
- Frame length: `(DATA_WIDTH+2)*CLKS_PER_BIT` cycles from the `tx` falling edge to the end of STOP.
- Back-to-back frames: minimum gap is 3 cycles of `tx`=1 beyond the stop bit (IDLE, FETCH, LOAD).
- `tx_done` is coincident with the last stop-bit cycle; it coincides with IDLE re-entry on the following edge.

## Test plan

- Reset: hold `RST_N`=0 for 3 cycles with `fifo_count`=5 -> `tx`=1, `busy`=0, `fifo_r_enable`=0 throughout.
- Single byte, `CLKS_PER_BIT`=4, FIFO model holding 0xA5, `count`=1:
  - `fifo_r_enable` pulses once.
  - `tx` carries 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 4 cycles.
  - Start bit falls 2 cycles after `r_enable`.
  - `tx_done` pulses once, 40 cycles after the start bit falls.
- Three bytes queued (0x00, 0xFF, 0x3C) -> exactly 3 `r_enable` pulses, frames in order, 3-cycle idle gaps, `fifo_count` reaches 0 with no fourth pop.
- Empty FIFO for 1000 cycles -> no `r_enable`, `tx`=1, `busy`=0.
- Reset asserted during data bit 3 of 0x5A -> `tx`=1 on the next edge, state IDLE. After release with `count`=0 there is no further activity.
- `fifo_count` drops to 0 during a frame -> the current frame completes unchanged and the block then idles.
